// File: rtl/bp_fe_mock_be_pkg.sv
// Shared types for the FE mock back-end checker.
// Holds the FE queue/command message formats the checker exchanges with the
// front end, the checker state enum, the status struct reported to the bench
// top, and a saturating counter helper.
package bp_fe_mock_be_pkg;

    localparam int bp_vaddr_width_gp    = 39;
    localparam int bp_instr_width_gp    = 32;
    localparam int bp_mock_cnt_width_gp = 16;

    typedef logic [bp_mock_cnt_width_gp-1:0] mock_cnt_t;

    typedef enum logic [1:0] {
        e_boot = 2'd0,
        e_run  = 2'd1,
        e_wait = 2'd2,
        e_done = 2'd3
    } mock_state_e;

    typedef enum logic {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_msg_type_e;

    typedef enum logic [1:0] {
        e_icache_miss        = 2'd0,
        e_illegal_instr      = 2'd1,
        e_itlb_miss          = 2'd2,
        e_instr_access_fault = 2'd3
    } bp_fe_exception_code_e;

    // For exceptions the pc field carries the faulting vaddr.
    typedef struct packed {
        bp_fe_msg_type_e              msg_type;
        bp_fe_exception_code_e        exception_code;
        logic [bp_vaddr_width_gp-1:0] pc;
        logic [bp_instr_width_gp-1:0] instr;
    } bp_fe_queue_s;

    typedef enum logic [1:0] {
        e_op_state_reset          = 2'd0,
        e_op_pc_redirection       = 2'd1,
        e_op_icache_fill_response = 2'd2,
        e_op_attaboy              = 2'd3
    } bp_fe_cmd_opcode_e;

    typedef struct packed {
        bp_fe_cmd_opcode_e            opcode;
        logic [bp_vaddr_width_gp-1:0] vaddr;
    } bp_fe_cmd_s;

    typedef struct packed {
        logic      done;
        logic      error;
        mock_cnt_t fetch_count;
        mock_cnt_t mismatch_count;
    } mock_status_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic mock_cnt_t sat_inc(input mock_cnt_t v);
        if (v == '1) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/bp_fe_mock_be_fifo.sv
// Small FIFO buffering FE queue entries for the mock back-end.
// Ports: clk_i/reset_n_i (async active-low), flush_i (synchronous, drops all
// contents including a same-cycle write), data_i/v_i/ready_o (ready/valid in),
// data_o/v_o/yumi_i (valid/yumi out). els_p must be a power of two.
module bp_fe_mock_be_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = $clog2(els_p);
    typedef logic [ptr_w_lp-1:0] ptr_t;
    typedef logic [ptr_w_lp:0]   cnt_t;
    localparam cnt_t els_lp = cnt_t'(els_p);

    logic [width_p-1:0] mem_r [els_p];
    ptr_t wr_ptr_r;
    ptr_t rd_ptr_r;
    cnt_t count_r;
    logic enq_s;
    logic deq_s;

    assign ready_o = (count_r != els_lp);
    assign v_o     = (count_r != cnt_t'(0));
    assign data_o  = mem_r[rd_ptr_r];
    assign enq_s   = v_i && ready_o;
    assign deq_s   = yumi_i && v_o;

    // Pointer and occupancy tracking; flush empties the buffer outright.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_t'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + cnt_t'(1);
                2'b01:   count_r <= count_r - cnt_t'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; pointers wrap naturally because els_p is a power of two.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_r[i] <= '0;
            end
        end else if (enq_s && !flush_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/bp_fe_mock_be_checker.sv
// Mock back-end for FE-only benches. Boots the FE with a state-reset command,
// drains the FE queue, answers icache misses with fill responses, checks each
// fetch against the external expected stream and can inject periodic PC
// redirects. Ports: FE queue in (fe_queue_i/_v_i/_ready_o), FE command out
// (fe_cmd_o/_v_o/_yumi_i), expected stream (exp_*), status (done_o, error_o,
// fetch_count_o, mismatch_count_o). Reset is asynchronous active-low.
module bp_fe_mock_be_checker
    import bp_fe_mock_be_pkg::*;
#(
    parameter int vaddr_width_p     = bp_vaddr_width_gp,
    parameter int instr_width_p     = bp_instr_width_gp,
    parameter int fe_queue_width_lp = $bits(bp_fe_queue_s),
    parameter int fe_cmd_width_lp   = $bits(bp_fe_cmd_s),
    parameter int in_els_p          = 4,
    parameter logic [vaddr_width_p-1:0] start_pc_p = 39'h00_8000_0000,
    parameter int redirect_period_p = 0,
    parameter int max_fetches_p     = 1024,
    parameter int cnt_width_p       = bp_mock_cnt_width_gp
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [fe_cmd_width_lp-1:0]   fe_cmd_o,
    output logic                         fe_cmd_v_o,
    input  logic                         fe_cmd_yumi_i,
    input  logic [vaddr_width_p-1:0]     exp_pc_i,
    input  logic [instr_width_p-1:0]     exp_instr_i,
    input  logic                         exp_v_i,
    output logic                         exp_yumi_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [cnt_width_p-1:0]       fetch_count_o,
    output logic [cnt_width_p-1:0]       mismatch_count_o
);

    localparam mock_cnt_t max_fetches_lp     = mock_cnt_t'(max_fetches_p);
    localparam mock_cnt_t redirect_period_lp = mock_cnt_t'(redirect_period_p);
    localparam logic      redirect_en_lp     = (redirect_period_p != 0);

    mock_state_e  state_r, state_n_s;
    bp_fe_cmd_s   cmd_r, cmd_n_s;
    logic         cmd_v_r, cmd_v_n_s;
    mock_status_s status_r, status_n_s;
    mock_cnt_t    since_r, since_n_s;
    logic         up_r;

    logic                         fifo_ready_s;
    logic                         fifo_v_s;
    logic                         fifo_yumi_s;
    logic                         fifo_flush_s;
    logic [fe_queue_width_lp-1:0] head_raw_s;
    bp_fe_queue_s                 head_s;
    logic                         cmd_yumi_s;
    logic                         redirect_s;
    logic                         match_s;
    logic                         exp_yumi_s;

    bp_fe_mock_be_fifo #(
        .width_p (fe_queue_width_lp),
        .els_p   (in_els_p)
    ) in_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (fifo_flush_s),
        .data_i    (fe_queue_i),
        .v_i       (fe_queue_v_i && fe_queue_ready_o),
        .ready_o   (fifo_ready_s),
        .data_o    (head_raw_s),
        .v_o       (fifo_v_s),
        .yumi_i    (fifo_yumi_s)
    );

    // up_r keeps ready low while in reset and for the first cycle after it.
    assign fe_queue_ready_o = up_r && fifo_ready_s && (state_r != e_done);
    assign head_s           = bp_fe_queue_s'(head_raw_s);
    assign cmd_yumi_s       = cmd_v_r && fe_cmd_yumi_i;
    assign match_s          = (head_s.pc == exp_pc_i) && (head_s.instr == exp_instr_i);
    assign redirect_s       = redirect_en_lp && exp_v_i && (since_r >= redirect_period_lp);

    assign fe_cmd_o         = cmd_r;
    assign fe_cmd_v_o       = cmd_v_r;
    assign exp_yumi_o       = exp_yumi_s;
    assign done_o           = status_r.done;
    assign error_o          = status_r.error;
    assign fetch_count_o    = cnt_width_p'(status_r.fetch_count);
    assign mismatch_count_o = cnt_width_p'(status_r.mismatch_count);

    // Next-state, command loading, buffer pop/flush and counter updates.
    always_comb begin
        state_n_s    = state_r;
        cmd_n_s      = cmd_r;
        cmd_v_n_s    = cmd_v_r && !cmd_yumi_s;
        status_n_s   = status_r;
        since_n_s    = since_r;
        fifo_yumi_s  = 1'b0;
        fifo_flush_s = 1'b0;
        exp_yumi_s   = 1'b0;
        case (state_r)
            e_boot: begin
                if (!cmd_v_r) begin
                    cmd_n_s.opcode = e_op_state_reset;
                    cmd_n_s.vaddr  = start_pc_p;
                    cmd_v_n_s      = 1'b1;
                end else if (cmd_yumi_s) begin
                    fifo_flush_s = 1'b1;
                    state_n_s    = e_run;
                end else begin
                    state_n_s = e_boot;
                end
            end
            e_run: begin
                // Commands are only issued from here, so the register is normally free.
                if (cmd_v_r) begin
                    state_n_s = e_run;
                end else if (redirect_s) begin
                    // Redirect beats the head entry; the head is flushed on yumi.
                    cmd_n_s.opcode = e_op_pc_redirection;
                    cmd_n_s.vaddr  = exp_pc_i;
                    cmd_v_n_s      = 1'b1;
                    since_n_s      = '0;
                    state_n_s      = e_wait;
                end else if (!fifo_v_s) begin
                    state_n_s = e_run;
                end else if (head_s.msg_type == e_fe_fetch) begin
                    if (exp_v_i) begin
                        fifo_yumi_s = 1'b1;
                        exp_yumi_s  = 1'b1;
                        if (match_s) begin
                            status_n_s.fetch_count = sat_inc(status_r.fetch_count);
                            since_n_s              = sat_inc(since_r);
                            if (status_n_s.fetch_count == max_fetches_lp) begin
                                status_n_s.done = 1'b1;
                                state_n_s       = e_done;
                            end else begin
                                state_n_s = e_run;
                            end
                        end else begin
                            status_n_s.mismatch_count = sat_inc(status_r.mismatch_count);
                            status_n_s.error          = 1'b1;
                        end
                    end else begin
                        // No expected entry yet: hold the fetch.
                        state_n_s = e_run;
                    end
                end else if (head_s.exception_code == e_icache_miss) begin
                    cmd_n_s.opcode = e_op_icache_fill_response;
                    cmd_n_s.vaddr  = head_s.pc;
                    cmd_v_n_s      = 1'b1;
                    fifo_yumi_s    = 1'b1;
                    state_n_s      = e_wait;
                end else begin
                    status_n_s.error = 1'b1;
                    fifo_yumi_s      = 1'b1;
                end
            end
            e_wait: begin
                // Everything fetched before the FE took the command is stale.
                if (cmd_yumi_s) begin
                    fifo_flush_s = 1'b1;
                    state_n_s    = e_run;
                end else begin
                    state_n_s = e_wait;
                end
            end
            e_done: begin
                state_n_s = e_done;
            end
            default: begin
                state_n_s = e_boot;
            end
        endcase
    end

    // State, command register, status and redirect spacing counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_boot;
            cmd_r    <= '0;
            cmd_v_r  <= 1'b0;
            status_r <= '0;
            since_r  <= '0;
            up_r     <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            cmd_r    <= cmd_n_s;
            cmd_v_r  <= cmd_v_n_s;
            status_r <= status_n_s;
            since_r  <= since_n_s;
            up_r     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_fe_mock_be_checker.sv
// Randomized bench for bp_fe_mock_be_checker. The bench plays the FE (a
// coherent fetch stream with occasional corrupt instructions, icache misses
// and other exceptions) and the expected-instruction source, and compares the
// DUT every cycle against a queue-based reference model of the checker rules.
`timescale 1ns/1ps
module tb_bp_fe_mock_be_checker;
    import bp_fe_mock_be_pkg::*;

    localparam int IN_ELS = 4;
    localparam int RP     = 5;
    localparam int MAXF   = 40;
    localparam logic [38:0] START_PC = 39'h00_8000_0000;
    localparam int PH_BOOT = 0, PH_RUN = 1, PH_WAIT = 2, PH_DONE = 3;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    bp_fe_queue_s fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [40:0]  fe_cmd_o;
    logic         fe_cmd_v_o;
    logic         fe_cmd_yumi_i;
    logic [38:0]  exp_pc_i;
    logic [31:0]  exp_instr_i;
    logic         exp_v_i;
    logic         exp_yumi_o;
    logic         done_o;
    logic         error_o;
    logic [15:0]  fetch_count_o;
    logic [15:0]  mismatch_count_o;

    bp_fe_mock_be_checker #(
        .in_els_p          (IN_ELS),
        .redirect_period_p (RP),
        .max_fetches_p     (MAXF)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_cmd_o         (fe_cmd_o),
        .fe_cmd_v_o       (fe_cmd_v_o),
        .fe_cmd_yumi_i    (fe_cmd_yumi_i),
        .exp_pc_i         (exp_pc_i),
        .exp_instr_i      (exp_instr_i),
        .exp_v_i          (exp_v_i),
        .exp_yumi_o       (exp_yumi_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .fetch_count_o    (fetch_count_o),
        .mismatch_count_o (mismatch_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_state;
    bp_fe_queue_s m_buf[$];
    bit           m_cmd_v;
    bp_fe_cmd_s   m_cmd;
    bit           m_live;
    int           m_fetch, m_mis, m_since;
    bit           m_err, m_done;
    // FE / expected-stream bookkeeping
    logic [38:0]  fe_pc, e_pc;
    bit           prev_v, prev_yumi, boot_checked;
    logic [40:0]  prev_cmd;

    function automatic logic [31:0] mem_f(input logic [38:0] pc);
        logic [31:0] t;
        t = pc[31:0];
        return (t * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = PH_BOOT;
        m_buf.delete();
        m_cmd_v = 1'b0;
        m_cmd   = '0;
        m_live  = 1'b0;
        m_fetch = 0;
        m_mis   = 0;
        m_since = 0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        fe_pc   = START_PC;
        e_pc    = START_PC;
        prev_v  = 1'b0;
        prev_yumi = 1'b0;
    endtask

    task automatic model_step(input bit acc, input bit redir);
        bit cv, cyumi, flush, pop;
        bp_fe_queue_s h;
        cv    = m_cmd_v;
        cyumi = cv && fe_cmd_yumi_i;
        flush = 1'b0;
        pop   = 1'b0;
        if (cyumi) m_cmd_v = 1'b0;
        case (m_state)
            PH_BOOT: begin
                if (!cv) begin
                    m_cmd.opcode = e_op_state_reset;
                    m_cmd.vaddr  = START_PC;
                    m_cmd_v      = 1'b1;
                end else if (cyumi) begin
                    flush = 1'b1;
                    m_state = PH_RUN;
                end
            end
            PH_RUN: begin
                if (!cv) begin
                    if (redir) begin
                        m_cmd.opcode = e_op_pc_redirection;
                        m_cmd.vaddr  = exp_pc_i;
                        m_cmd_v      = 1'b1;
                        m_since      = 0;
                        m_state      = PH_WAIT;
                    end else if (m_buf.size() > 0) begin
                        h = m_buf[0];
                        if (h.msg_type == e_fe_fetch) begin
                            if (exp_v_i) begin
                                pop = 1'b1;
                                if (h.pc == exp_pc_i && h.instr == exp_instr_i) begin
                                    m_fetch = sat16(m_fetch);
                                    m_since++;
                                    if (m_fetch == MAXF) begin
                                        m_done  = 1'b1;
                                        m_state = PH_DONE;
                                    end
                                end else begin
                                    m_mis = sat16(m_mis);
                                    m_err = 1'b1;
                                end
                            end
                        end else if (h.exception_code == e_icache_miss) begin
                            m_cmd.opcode = e_op_icache_fill_response;
                            m_cmd.vaddr  = h.pc;
                            m_cmd_v      = 1'b1;
                            pop          = 1'b1;
                            m_state      = PH_WAIT;
                        end else begin
                            m_err = 1'b1;
                            pop   = 1'b1;
                        end
                    end
                end
            end
            PH_WAIT: begin
                if (cyumi) begin
                    flush = 1'b1;
                    m_state = PH_RUN;
                end
            end
            default: ;
        endcase
        if (pop) void'(m_buf.pop_front());
        if (acc) m_buf.push_back(fe_queue_i);
        if (flush) m_buf.delete();
        m_live = 1'b1;
    endtask

    // One clock of stimulus, comparison and model update.
    task automatic do_cycle(input bit hold_yumi, input bit force_push);
        bp_fe_queue_s e;
        int r;
        logic [1:0] code;
        bit m_ready, m_redir, m_eyumi, acc;
        @(negedge clk_i);
        fe_cmd_yumi_i = m_cmd_v && !hold_yumi && ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 99);
        e = '0;
        e.msg_type = e_fe_fetch;
        e.pc       = fe_pc;
        e.instr    = mem_f(fe_pc);
        if (r < 6) begin
            e.instr = e.instr ^ 32'h0000_0100;
        end else if (r < 14) begin
            e.msg_type       = e_fe_exception;
            e.exception_code = e_icache_miss;
            e.instr          = 32'h0;
        end else if (r < 17) begin
            code = 2'($urandom_range(1, 3));
            e.msg_type       = e_fe_exception;
            e.exception_code = bp_fe_exception_code_e'(code);
            e.pc             = 39'($urandom);
        end
        fe_queue_i   = e;
        fe_queue_v_i = force_push || ($urandom_range(0, 9) < 7);
        exp_v_i      = ($urandom_range(0, 9) < 8);
        exp_pc_i     = e_pc;
        exp_instr_i  = mem_f(e_pc);
        #1;
        m_ready = m_live && (m_buf.size() < IN_ELS) && (m_state != PH_DONE);
        m_redir = (m_state == PH_RUN) && !m_cmd_v && exp_v_i && (m_since >= RP);
        m_eyumi = (m_state == PH_RUN) && !m_cmd_v && !m_redir && (m_buf.size() > 0)
                  && (m_buf[0].msg_type == e_fe_fetch) && exp_v_i;
        chk("ready", 64'(fe_queue_ready_o), 64'(m_ready));
        chk("cmd_v", 64'(fe_cmd_v_o), 64'(m_cmd_v));
        if (m_cmd_v) chk("cmd", 64'(fe_cmd_o), 64'(m_cmd));
        chk("exp_yumi", 64'(exp_yumi_o), 64'(m_eyumi));
        chk("done", 64'(done_o), 64'(m_done));
        chk("error", 64'(error_o), 64'(m_err));
        chk("fetch_count", 64'(fetch_count_o), 64'(m_fetch));
        chk("mismatch_count", 64'(mismatch_count_o), 64'(m_mis));
        if (prev_v && !prev_yumi) chk("cmd_hold", 64'(fe_cmd_o), 64'(prev_cmd));
        if (!boot_checked && m_state == PH_BOOT && m_cmd_v) begin
            chk("boot_cmd_literal", 64'(fe_cmd_o), {23'd0, 2'b00, 39'h00_8000_0000});
            boot_checked = 1'b1;
        end
        prev_v    = fe_cmd_v_o;
        prev_yumi = fe_cmd_yumi_i;
        prev_cmd  = fe_cmd_o;
        acc = fe_queue_v_i && m_ready;
        if (acc && e.msg_type == e_fe_fetch) fe_pc = fe_pc + 39'd4;
        if (m_eyumi) e_pc = e_pc + 39'd4;
        if (m_cmd_v && fe_cmd_yumi_i) fe_pc = m_cmd.vaddr;
        model_step(acc, m_redir);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(fe_queue_ready_o), 64'd0);
        chk({tag, "_cmd_v"}, 64'(fe_cmd_v_o), 64'd0);
        chk({tag, "_cmd"}, 64'(fe_cmd_o), 64'd0);
        chk({tag, "_exp_yumi"}, 64'(exp_yumi_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_error"}, 64'(error_o), 64'd0);
        chk({tag, "_fetch"}, 64'(fetch_count_o), 64'd0);
        chk({tag, "_mismatch"}, 64'(mismatch_count_o), 64'd0);
    endtask

    initial begin
        int n;
        reset_n_i     = 1'b0;
        fe_queue_i    = '0;
        fe_queue_v_i  = 1'b0;
        fe_cmd_yumi_i = 1'b0;
        exp_pc_i      = '0;
        exp_instr_i   = '0;
        exp_v_i       = 1'b0;
        boot_checked  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        chk_all_zero("reset");
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        // Random run until the required number of matching fetches.
        n = 0;
        while (!m_done && n < 6000) begin
            do_cycle(1'b0, 1'b0);
            n++;
        end
        if (!m_done) begin
            checks++;
            errors++;
            $display("FAIL timeout_done actual=%0d required=%0d", m_fetch, MAXF);
        end
        repeat (8) do_cycle(1'b0, 1'b1);
        chk("final_done", 64'(done_o), 64'd1);
        chk("final_fetch", 64'(fetch_count_o), 64'd40);
        chk("final_ready", 64'(fe_queue_ready_o), 64'd0);
        chk("final_cmd_v", 64'(fe_cmd_v_o), 64'd0);

        // Second boot: park in the wait state with the FE withholding yumi.
        @(negedge clk_i);
        reset_n_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        n = 0;
        while (!(m_state == PH_WAIT && m_cmd_v) && n < 2000) begin
            do_cycle(m_state == PH_WAIT, 1'b0);
            n++;
        end
        if (!(m_state == PH_WAIT && m_cmd_v)) begin
            checks++;
            errors++;
            $display("FAIL timeout_wait actual=%0d required=%0d", m_state, PH_WAIT);
        end
        repeat (10) do_cycle(1'b1, 1'b1);
        #1;
        chk("held_cmd_v", 64'(fe_cmd_v_o), 64'd1);
        chk("full_ready", 64'(fe_queue_ready_o), 64'd0);

        // Asynchronous reset in the middle of the wait.
        @(negedge clk_i);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("async_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
